// File: rtl/dps_decoder_11.sv
// Two-stage pipelined decoder for the 11-wire Fibonacci crosstalk-avoidance code.
// The codeword is registered, split into low/high partial sums, then summed, range-checked and counted.
module dps_decoder_11 #(
    parameter int DW  = 9,
    parameter int ECW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [10:0]    codein,
    input  logic           codein_valid,
    output logic [DW-1:0]  dataout,
    output logic           dataout_valid,
    output logic           err,
    output logic [ECW-1:0] err_count
);

    localparam logic [9:0] FNS01 = 10'd1;
    localparam logic [9:0] FNS02 = 10'd1;
    localparam logic [9:0] FNS03 = 10'd2;
    localparam logic [9:0] FNS04 = 10'd3;
    localparam logic [9:0] FNS05 = 10'd5;
    localparam logic [9:0] FNS06 = 10'd8;
    localparam logic [9:0] FNS07 = 10'd13;
    localparam logic [9:0] FNS08 = 10'd21;
    localparam logic [9:0] FNS09 = 10'd34;
    localparam logic [9:0] FNS10 = 10'd55;
    localparam logic [9:0] FNS11 = 10'd89;

    // Wire 9 carries double weight; this is what lets 11 wires reach 287.
    localparam logic [9:0] WEIGHT [11] = '{
        FNS01, FNS02, FNS03, FNS04, FNS05, FNS06,
        FNS07, FNS08, FNS09, 10'(2 * FNS10), FNS11
    };

    logic [10:0]    c0_q;
    logic           v0_q;
    logic [5:0]     pl_q, pl_d;
    logic [8:0]     ph_q, ph_d;
    logic           v1_q;
    logic [9:0]     sum_d;
    logic [DW-1:0]  dataout_q, dataout_d;
    logic           dataout_valid_q;
    logic           err_q, err_d;
    logic [ECW-1:0] err_count_q, err_count_d;

    always_comb begin
        pl_d = '0;
        for (int i = 0; i < 6; i++) begin
            if (c0_q[i]) pl_d = pl_d + WEIGHT[i][5:0];
        end
        ph_d = '0;
        for (int i = 6; i < 11; i++) begin
            if (c0_q[i]) ph_d = ph_d + WEIGHT[i][8:0];
        end
    end

    always_comb begin
        sum_d       = 10'(pl_q) + 10'(ph_q);
        dataout_d   = DW'(sum_d);
        err_d       = v1_q && ((sum_d >> DW) != '0);
        err_count_d = err_count_q;
        if (err_d && (err_count_q != '1)) err_count_d = err_count_q + ECW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c0_q            <= '0;
            v0_q            <= 1'b0;
            pl_q            <= '0;
            ph_q            <= '0;
            v1_q            <= 1'b0;
            dataout_q       <= '0;
            dataout_valid_q <= 1'b0;
            err_q           <= 1'b0;
            err_count_q     <= '0;
        end else begin
            c0_q            <= codein;
            v0_q            <= codein_valid;
            pl_q            <= pl_d;
            ph_q            <= ph_d;
            v1_q            <= v0_q;
            dataout_q       <= dataout_d;
            dataout_valid_q <= v1_q;
            err_q           <= err_d;
            err_count_q     <= err_count_d;
        end
    end

    assign dataout       = dataout_q;
    assign dataout_valid = dataout_valid_q;
    assign err           = err_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_dps_decoder_11.sv
// Bench for dps_decoder_11: a wide instance (DW=9) and a narrow one (DW=8, ECW=2) share stimulus
// and are checked every cycle against a history-based model plus literal expectations.
module tb_dps_decoder_11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] codein = 11'h7FF;
    logic        codein_valid = 1'b1;

    logic [8:0] da;  logic dva, ea; logic [7:0] ca;
    logic [7:0] db;  logic dvb, eb; logic [1:0] cb;

    always #5 clock = ~clock;

    dps_decoder_11 #(.DW(9), .ECW(8)) u_a (
        .clock(clock), .reset(reset), .codein(codein), .codein_valid(codein_valid),
        .dataout(da), .dataout_valid(dva), .err(ea), .err_count(ca)
    );

    dps_decoder_11 #(.DW(8), .ECW(2)) u_b (
        .clock(clock), .reset(reset), .codein(codein), .codein_valid(codein_valid),
        .dataout(db), .dataout_valid(dvb), .err(eb), .err_count(cb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fib_value(input logic [10:0] c);
        int w [11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 110, 89};
        int s = 0;
        for (int i = 0; i < 11; i++) if (c[i]) s += w[i];
        return s;
    endfunction

    // Model: output after edge e is the word captured at edge e-2, unless reset was seen at e-2..e.
    localparam int HMAX = 4096;
    logic [10:0] hc [HMAX];
    logic        hv [HMAX];
    logic        hr [HMAX];
    int edge_n = -1;
    int exp_da, exp_va, exp_ea, exp_ca, exp_db, exp_vb, exp_eb, exp_cb;
    initial begin
        exp_da = 0; exp_va = 0; exp_ea = 0; exp_ca = 0;
        exp_db = 0; exp_vb = 0; exp_eb = 0; exp_cb = 0;
    end

    always @(posedge clock) begin
        int s;
        edge_n++;
        if (edge_n < HMAX) begin
            hc[edge_n] = codein; hv[edge_n] = codein_valid; hr[edge_n] = reset;
        end
        exp_da = 0; exp_va = 0; exp_ea = 0; exp_db = 0; exp_vb = 0; exp_eb = 0;
        if (reset) begin
            exp_ca = 0; exp_cb = 0;
        end else if (edge_n >= 2 && edge_n < HMAX && !hr[edge_n-1] && !hr[edge_n-2]) begin
            s = fib_value(hc[edge_n-2]);
            exp_va = int'(hv[edge_n-2]);
            exp_vb = exp_va;
            exp_da = s % 512;
            exp_db = s % 256;
            exp_ea = (exp_va == 1 && s >= 512) ? 1 : 0;
            exp_eb = (exp_vb == 1 && s >= 256) ? 1 : 0;
            if (exp_ea == 1 && exp_ca < 255) exp_ca++;
            if (exp_eb == 1 && exp_cb < 3)   exp_cb++;
        end
    end

    int qa [$];
    int qb_data [$];
    int qb_cnt [$];

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_da", int'(da), 0);  chk("rst_va", int'(dva), 0);
            chk("rst_ea", int'(ea), 0);  chk("rst_ca", int'(ca), 0);
            chk("rst_db", int'(db), 0);  chk("rst_vb", int'(dvb), 0);
            chk("rst_eb", int'(eb), 0);  chk("rst_cb", int'(cb), 0);
        end else begin
            chk("a_valid", int'(dva), exp_va);
            chk("a_err", int'(ea), exp_ea);
            chk("a_count", int'(ca), exp_ca);
            chk("b_valid", int'(dvb), exp_vb);
            chk("b_err", int'(eb), exp_eb);
            chk("b_count", int'(cb), exp_cb);
            if (exp_va == 1) chk("a_data", int'(da), exp_da);
            if (exp_vb == 1) chk("b_data", int'(db), exp_db);
        end
        if (dva) qa.push_back(int'(da));
        if (dvb) begin
            qb_data.push_back(int'(db));
            qb_cnt.push_back(int'(cb));
        end
    end

    task automatic drive(input logic [10:0] c, input logic v, input logic r);
        @(posedge clock);
        #1;
        codein = c; codein_valid = v; reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(11'h000, 1'b0, 1'b0);
    endtask

    initial begin
        int sweep [11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 110, 89};
        int cnt_exp [4] = '{1, 2, 3, 3};
        logic [10:0] one;

        // Reset held with all-ones valid input: outputs stay zero.
        repeat (3) drive(11'h7FF, 1'b1, 1'b1);
        chk("held_reset_dataout", int'(da), 0);
        chk("held_reset_valid", int'(dva), 0);
        qa.delete(); qb_data.delete(); qb_cnt.delete();
        drive(11'h7FF, 1'b1, 1'b0);
        idle(4);
        chk("release_count", qa.size(), 1);
        if (qa.size() > 0) chk("release_data_287", qa[0], 287);
        if (qb_data.size() > 0) chk("release_narrow_31", qb_data[0], 31);

        // One-hot sweep, back to back.
        drive(11'h000, 1'b0, 1'b1);
        qa.delete();
        one = 11'h001;
        for (int i = 0; i < 11; i++) begin
            drive(one, 1'b1, 1'b0);
            one = one << 1;
        end
        idle(4);
        chk("sweep_count", qa.size(), 11);
        for (int i = 0; i < 11 && i < qa.size(); i++) chk("sweep_value", qa[i], sweep[i]);

        // Valid gating with a fixed codeword.
        qa.delete();
        for (int k = 0; k < 8; k++) drive(11'b100_0000_0001, (k % 2) == 0, 1'b0);
        idle(4);
        chk("gate_count", qa.size(), 4);
        foreach (qa[i]) chk("gate_value_90", qa[i], 90);

        // Overflow and saturation on the narrow instance.
        drive(11'h000, 1'b0, 1'b1);
        qb_data.delete(); qb_cnt.delete();
        repeat (4) drive(11'h7FF, 1'b1, 1'b0);
        idle(4);
        chk("ovf_count", qb_cnt.size(), 4);
        for (int i = 0; i < 4 && i < qb_cnt.size(); i++) begin
            chk("ovf_data_31", qb_data[i], 31);
            chk("ovf_err_count", qb_cnt[i], cnt_exp[i]);
        end
        repeat (4) drive(11'h7FF, 1'b0, 1'b0);
        idle(4);
        chk("invalid_ovf_hold", int'(cb), 3);
        chk("invalid_ovf_no_output", qb_cnt.size(), 4);

        // Reset while words are in flight.
        qa.delete();
        drive(11'h001, 1'b1, 1'b0);
        drive(11'h004, 1'b1, 1'b0);
        drive(11'h400, 1'b1, 1'b1);
        drive(11'h010, 1'b1, 1'b0);
        idle(4);
        chk("midreset_count", qa.size(), 1);
        if (qa.size() > 0) chk("midreset_first", qa[0], 5);
        chk("midreset_cnt_b", int'(cb), 0);

        // Random codewords, random valid, occasional reset.
        for (int k = 0; k < 300; k++)
            drive(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
